// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM/WB operand info in, stall/flush/forward controls out.
// Latency: pure wiring, no storage.
// Backpressure: none; the stall/flush outputs are the pipeline's backpressure.
//
// Signals
//   id_*          : instruction in ID (valid, sources, which sources are read)
//   ex_*          : instruction in EX (sources, dest, write enable, load flag, taken redirect)
//   mem_*, wb_*   : older producers for forwarding
//   stall_*, flush_*, fwd_*_sel, *_cnt : controller outputs
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_rf_we;
    logic             ex_is_load;
    logic             ex_br_taken;
    logic [4:0]       mem_rd;
    logic             mem_rf_we;
    logic             mem_is_load;
    logic [4:0]       wb_rd;
    logic             wb_rf_we;
    logic             stall_pc;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies stage info, consumes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_rf_we, ex_is_load, ex_br_taken,
        output mem_rd, mem_rf_we, mem_is_load, wb_rd, wb_rf_we,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
        input  fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_rf_we, ex_is_load, ex_br_taken,
        input  mem_rd, mem_rf_we, mem_is_load, wb_rd, wb_rf_we,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
        output fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage BRAM pipeline: load-use stalls, redirect flushes, EX forwarding, perf counters.
// Latency: controls are combinational in the hazard cycle; stall lasts MEM_LAT cycles, flush_if_id IMEM_LAT+1 cycles.
// Backpressure: stall_pc/stall_if_id hold the front end; flush_* insert bubbles; redirect overrides stall.
//
// Ports
//   clk  : clock
//   rstn : asynchronous active-low reset; forces FSM to RUN and all outputs to 0
//   hz   : hazard_ctrl_if.slave bundle (stage info in, stall/flush/forward/counters out)
module hazard_ctrl #(
    parameter int MEM_LAT  = 1,
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rstn,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, REDIRECT} state_t;

    localparam logic [1:0] LP_LU_CNT = 2'(MEM_LAT - 1);
    localparam logic [1:0] LP_RD_CNT = 2'(IMEM_LAT);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [1:0]       r_cnt;
    logic [1:0]       w_nxt_cnt;
    logic             w_lu_hit;
    logic             w_stall;
    logic             w_flush_if_id;
    logic             w_flush_id_ex;
    logic [1:0]       w_fwd1;
    logic [1:0]       w_fwd2;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Youngest non-load producer in MEM beats WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] m_rd, input logic m_we, input logic m_ld,
                                           input logic [4:0] w_rd, input logic w_we);
        if (r == 5'd0)                      return 2'd0;
        else if (m_we && !m_ld && m_rd == r) return 2'd1;
        else if (w_we && w_rd == r)         return 2'd2;
        else                                return 2'd0;
    endfunction

    assign w_lu_hit = hz.id_valid && hz.ex_is_load && hz.ex_rf_we && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                       (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_stall       = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        case (r_state)
            RUN, LU_STALL: begin
                if (hz.ex_br_taken) begin
                    // A redirect kills the ID instruction, so any stall is moot.
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_nxt_cnt     = LP_RD_CNT;
                    w_nxt_state   = REDIRECT;
                end else if (r_state == LU_STALL) begin
                    w_stall       = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_nxt_cnt     = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) w_nxt_state = RUN;
                end else if (w_lu_hit) begin
                    w_stall       = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_nxt_cnt     = LP_LU_CNT;
                    w_nxt_state   = (LP_LU_CNT != 2'd0) ? LU_STALL : RUN;
                end
            end
            REDIRECT: begin
                // Load-use in ID is irrelevant: that instruction is being flushed.
                w_flush_if_id = 1'b1;
                if (hz.ex_br_taken) begin
                    w_flush_id_ex = 1'b1;
                    w_nxt_cnt     = LP_RD_CNT;
                end else begin
                    w_nxt_cnt = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) w_nxt_state = RUN;
                end
            end
            default: begin
                w_nxt_state = RUN;
                w_nxt_cnt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RUN;
            r_cnt       <= 2'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
            r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush_if_id);
        end
    end

    assign w_fwd1 = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_rf_we, hz.mem_is_load, hz.wb_rd, hz.wb_rf_we);
    assign w_fwd2 = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_rf_we, hz.mem_is_load, hz.wb_rd, hz.wb_rf_we);

    // Combinational outputs are gated so reset drives every output to 0 immediately.
    assign hz.stall_pc    = rstn & w_stall;
    assign hz.stall_if_id = rstn & w_stall;
    assign hz.flush_if_id = rstn & w_flush_if_id;
    assign hz.flush_id_ex = rstn & w_flush_id_ex;
    assign hz.fwd_rs1_sel = rstn ? w_fwd1 : 2'd0;
    assign hz.fwd_rs2_sel = rstn ? w_fwd2 : 2'd0;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus drives two instances: A (MEM_LAT=1) and B (MEM_LAT=3).
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_rf_we, ex_is_load, ex_br_taken, mem_rf_we, mem_is_load, wb_rf_we;

    hazard_ctrl_if #(.CNT_W(CNT_W)) ifa ();
    hazard_ctrl_if #(.CNT_W(CNT_W)) ifb ();

    assign ifa.id_valid = id_valid;      assign ifb.id_valid = id_valid;
    assign ifa.id_rs1 = id_rs1;          assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;          assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1;  assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2;  assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.ex_rs1 = ex_rs1;          assign ifb.ex_rs1 = ex_rs1;
    assign ifa.ex_rs2 = ex_rs2;          assign ifb.ex_rs2 = ex_rs2;
    assign ifa.ex_rd = ex_rd;            assign ifb.ex_rd = ex_rd;
    assign ifa.ex_rf_we = ex_rf_we;      assign ifb.ex_rf_we = ex_rf_we;
    assign ifa.ex_is_load = ex_is_load;  assign ifb.ex_is_load = ex_is_load;
    assign ifa.ex_br_taken = ex_br_taken; assign ifb.ex_br_taken = ex_br_taken;
    assign ifa.mem_rd = mem_rd;          assign ifb.mem_rd = mem_rd;
    assign ifa.mem_rf_we = mem_rf_we;    assign ifb.mem_rf_we = mem_rf_we;
    assign ifa.mem_is_load = mem_is_load; assign ifb.mem_is_load = mem_is_load;
    assign ifa.wb_rd = wb_rd;            assign ifb.wb_rd = wb_rd;
    assign ifa.wb_rf_we = wb_rf_we;      assign ifb.wb_rf_we = wb_rf_we;

    hazard_ctrl #(.MEM_LAT(1), .IMEM_LAT(1), .CNT_W(CNT_W)) dut_a (.clk(clk), .rstn(rstn), .hz(ifa));
    hazard_ctrl #(.MEM_LAT(3), .IMEM_LAT(1), .CNT_W(CNT_W)) dut_b (.clk(clk), .rstn(rstn), .hz(ifb));

    // ctl = {stall_pc, stall_if_id, flush_if_id, flush_id_ex}
    typedef struct packed {
        logic [3:0]       ctl_a;
        logic [3:0]       ctl_b;
        logic [1:0]       fwd1;
        logic [1:0]       fwd2;
        logic [CNT_W-1:0] sc_a;
        logic [CNT_W-1:0] fc_a;
        logic [CNT_W-1:0] sc_b;
        logic [CNT_W-1:0] fc_b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   stepno = 0;
    logic [CNT_W-1:0] run_sc_a, run_fc_a, run_sc_b, run_fc_b;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_in();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_rf_we = 0; ex_is_load = 0; ex_br_taken = 0;
        mem_rf_we = 0; mem_is_load = 0; wb_rf_we = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1);
        id_valid = 1; id_use_rs1 = 1; id_rs1 = rs1;
        ex_is_load = 1; ex_rf_we = 1; ex_rd = rd;
    endtask

    // Called just after a posedge with inputs applied: push expectation,
    // compare at the negedge, then advance to just after the next posedge.
    task automatic step(input logic [3:0] ea, input logic [3:0] eb,
                        input logic [1:0] f1, input logic [1:0] f2);
        exp_t e;
        exp_t g;
        e.ctl_a = ea; e.ctl_b = eb; e.fwd1 = f1; e.fwd2 = f2;
        e.sc_a = run_sc_a; e.fc_a = run_fc_a; e.sc_b = run_sc_b; e.fc_b = run_fc_b;
        exp_q.push_back(e);
        run_sc_a += CNT_W'(ea[3]); run_fc_a += CNT_W'(ea[1]);
        run_sc_b += CNT_W'(eb[3]); run_fc_b += CNT_W'(eb[1]);
        @(negedge clk);
        g = exp_q.pop_front();
        stepno++;
        cmp($sformatf("s%0d ctl_a", stepno),
            32'({ifa.stall_pc, ifa.stall_if_id, ifa.flush_if_id, ifa.flush_id_ex}), 32'(g.ctl_a));
        cmp($sformatf("s%0d ctl_b", stepno),
            32'({ifb.stall_pc, ifb.stall_if_id, ifb.flush_if_id, ifb.flush_id_ex}), 32'(g.ctl_b));
        cmp($sformatf("s%0d fwd", stepno),
            32'({ifa.fwd_rs1_sel, ifa.fwd_rs2_sel, ifb.fwd_rs1_sel, ifb.fwd_rs2_sel}),
            32'({g.fwd1, g.fwd2, g.fwd1, g.fwd2}));
        cmp($sformatf("s%0d stall_cnt_a", stepno), ifa.stall_cnt, g.sc_a);
        cmp($sformatf("s%0d flush_cnt_a", stepno), ifa.flush_cnt, g.fc_a);
        cmp($sformatf("s%0d stall_cnt_b", stepno), ifb.stall_cnt, g.sc_b);
        cmp($sformatf("s%0d flush_cnt_b", stepno), ifb.flush_cnt, g.fc_b);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        cmp({tag, " ctl_a"}, 32'({ifa.stall_pc, ifa.stall_if_id, ifa.flush_if_id, ifa.flush_id_ex}), 32'd0);
        cmp({tag, " ctl_b"}, 32'({ifb.stall_pc, ifb.stall_if_id, ifb.flush_if_id, ifb.flush_id_ex}), 32'd0);
        cmp({tag, " fwd"}, 32'({ifa.fwd_rs1_sel, ifa.fwd_rs2_sel, ifb.fwd_rs1_sel, ifb.fwd_rs2_sel}), 32'd0);
        cmp({tag, " cnt_a"}, ifa.stall_cnt | ifa.flush_cnt, 32'd0);
        cmp({tag, " cnt_b"}, ifb.stall_cnt | ifb.flush_cnt, 32'd0);
    endtask

    initial begin
        run_sc_a = 0; run_fc_a = 0; run_sc_b = 0; run_fc_b = 0;
        clr_in();
        // Reset state, with forwarding inputs that would otherwise select MEM.
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_rf_we = 1;
        #12;
        chk_all_zero("reset");
        clr_in();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;

        step(4'b0000, 4'b0000, 2'd0, 2'd0);               // idle

        // Load-use on rs1: A stalls 1 cycle, B stalls 3.
        set_lu(5'd5, 5'd5);
        step(4'b1101, 4'b1101, 2'd0, 2'd0);
        clr_in();
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Load into x0 never stalls.
        set_lu(5'd0, 5'd0);
        step(4'b0000, 4'b0000, 2'd0, 2'd0);
        // Load-use via rs2 only; id_valid=0 does not stall.
        clr_in();
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd9; id_rs1 = 5'd9;
        ex_is_load = 1; ex_rf_we = 1; ex_rd = 5'd9;
        step(4'b1101, 4'b1101, 2'd0, 2'd0);
        clr_in();
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        set_lu(5'd7, 5'd7); id_valid = 0;
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Redirect: flush_if_id 2 cycles, flush_id_ex first only.
        clr_in(); ex_br_taken = 1;
        step(4'b0011, 4'b0011, 2'd0, 2'd0);
        clr_in();
        step(4'b0010, 4'b0010, 2'd0, 2'd0);
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Branch and load-use together: redirect wins; lu_hit ignored in REDIRECT.
        set_lu(5'd5, 5'd5); ex_br_taken = 1;
        step(4'b0011, 4'b0011, 2'd0, 2'd0);
        ex_br_taken = 0;
        step(4'b0010, 4'b0010, 2'd0, 2'd0);
        clr_in();
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Second redirect restarts the flush window.
        ex_br_taken = 1;
        step(4'b0011, 4'b0011, 2'd0, 2'd0);
        step(4'b0011, 4'b0011, 2'd0, 2'd0);
        clr_in();
        step(4'b0010, 4'b0010, 2'd0, 2'd0);
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Forwarding.
        ex_rs1 = 5'd3; ex_rs2 = 5'd0;
        mem_rd = 5'd3; mem_rf_we = 1; wb_rd = 5'd3; wb_rf_we = 1;
        step(4'b0000, 4'b0000, 2'd1, 2'd0);
        mem_is_load = 1;
        step(4'b0000, 4'b0000, 2'd2, 2'd0);
        ex_rs2 = 5'd3; mem_is_load = 0; mem_rd = 5'd4;
        step(4'b0000, 4'b0000, 2'd2, 2'd2);
        mem_rd = 5'd3; wb_rf_we = 0; mem_is_load = 1;
        step(4'b0000, 4'b0000, 2'd0, 2'd0);
        ex_rs1 = 5'd0; mem_rd = 5'd0; mem_is_load = 0; wb_rd = 5'd0; wb_rf_we = 1;
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        // Reset during the 2nd cycle of B's 3-cycle stall.
        clr_in();
        set_lu(5'd5, 5'd5);
        step(4'b1101, 4'b1101, 2'd0, 2'd0);
        clr_in();
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_rf_we = 1;
        rstn = 0;
        #1;
        chk_all_zero("midreset");
        run_sc_a = 0; run_fc_a = 0; run_sc_b = 0; run_fc_b = 0;
        clr_in();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        set_lu(5'd5, 5'd5);
        step(4'b1101, 4'b1101, 2'd0, 2'd0);
        clr_in();
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        step(4'b0000, 4'b1101, 2'd0, 2'd0);
        step(4'b0000, 4'b0000, 2'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
